exec_unit_seq: RTL and testbench
================================

Name: exec_unit_seq

Overview:
- Sequenced successor to the combinational execution stage.
- Latches one operation on a valid/ready handshake, selecting each operand from the decode path or the forwarding (UA) path. Then executes an integer, fixed-point or vector ADD/SUB/MUL.
- Vector ops are processed LANES_PER_CYCLE lanes per clock. The registered result and N/V/Z flags are held until the write-back stage accepts them.
- Sits between decode/forwarding and write-back.

Parameters:
- DATA_WIDTH, 16, element width in bits (scalar and per vector lane).
- LANES, 16, vector lanes. Must be a multiple of LANES_PER_CYCLE.
- LANES_PER_CYCLE, 4, lanes computed per clock in vector mode.
- FRAC_BITS, 8, fractional bits of the fixed-point format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept an operation.
- opcode  in  5  [4:3] class: 00 int, 01 fixed, 10 vector, 11 illegal; [2:0] op: 000 ADD, 001 SUB, 010 MUL, others illegal.
- s_mux_A  in  1  A operand select: 0 decode, 1 UA.
- s_mux_B  in  1  B operand select: 0 decode, 1 UA.
- A_deco, B_deco, A_ua, B_ua  in  DATA_WIDTH  scalar operands (int and fixed share them).
- A_deco_vec, B_deco_vec, A_ua_vec, B_ua_vec  in  LANES*DATA_WIDTH  vector operands; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result available.
- out_ready  in  1  write-back accepts result.
- out_scalar  out  DATA_WIDTH  int/fixed result.
- out_vector  out  LANES*DATA_WIDTH  vector result.
- out_class  out  2  class of the held result.
- N, V, Z  out  1  scalar flags.
- N_vec, V_vec, Z_vec  out  LANES  per-lane flags.
- illegal_op  out  1  held result came from an illegal opcode.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; all outputs 0, except in_ready=1. Reset mid-operation abandons the operation; nothing is emitted.
- FSM states: IDLE, SCALAR, VEC, HOLD.
- in_ready=1 only in IDLE.
- Accept: in_valid & in_ready. On accept, the unit latches opcode and the muxed operands (mux applied at accept; later input changes are ignored).
- IDLE -> SCALAR for int, fixed or illegal. IDLE -> VEC for vector.
- SCALAR: compute in one cycle, then -> HOLD. Latency accept-to-out_valid = 2 edges: accepted at edge t, out_valid high after edge t+2.
- VEC: chunk counter 0..LANES/LANES_PER_CYCLE-1. Each cycle writes lanes [k*LPC, (k+1)*LPC) of the result and flags. After the last chunk -> HOLD. Vector latency = LANES/LANES_PER_CYCLE+1 edges (default 5).
- HOLD: out_valid=1; outputs stable. When out_ready=1 -> IDLE and out_valid drops on that edge. in_valid during HOLD is ignored (in_ready=0).
- Lanes are not written on a scalar op, and out_scalar is not written on a vector op; both keep their previous values. Only the flags for the executed class are updated.
- Integer: two's complement, wrap.
  - ADD/SUB: V is signed overflow.
  - MUL: 2*DATA_WIDTH product, low DATA_WIDTH kept; V=1 if the product does not sign-fit in DATA_WIDTH.
- Fixed:
  - ADD/SUB are the same as integer.
  - MUL: 2*DATA_WIDTH product arithmetic-shifted right by FRAC_BITS (truncate toward -inf). Low DATA_WIDTH kept; V=1 if the shifted value does not sign-fit.
- Vector: per lane, integer rules; per-lane flags.
- N = result MSB; Z = result==0 (after wrap or saturation).
- Illegal opcode: goes through SCALAR; out_scalar=0, Z=1, N=0, V=0, illegal_op=1. The illegal_op bit is cleared on the next accepted legal op.
- Simultaneous out_ready and in_valid in HOLD: the result retires and the new op is not accepted until the following cycle (IDLE).

Optional Feature:
- Macro: EXEC_SATURATE_EN.
- Defined: on any overflow (V=1) the result is clamped to the signed max (0x7FFF at 16 bits) if the true result is positive, else the signed min (0x8000). V is still asserted. Applies to all classes.
- Undefined: wrap as specified above.

Test Plan:
- Int ADD, s_mux_A=0, s_mux_B=1, A_deco=0x0005, B_ua=0x0003 -> out_scalar=0x0008, N=0, V=0, Z=0, out_valid 2 edges after accept.
- Int ADD 0x7FFF+0x0001 -> 0x8000, N=1, V=1. With EXEC_SATURATE_EN -> 0x7FFF, V=1.
- Fixed MUL (FRAC_BITS=8) 0x0180 (1.5) * 0x0200 (2.0) -> 0x0300 (3.0), V=0. Fixed SUB 0x0100-0x0100 -> 0x0000, Z=1.
- Vector SUB, lane i: A=i, B=1 -> lane0=0xFFFF with N_vec[0]=1; lane1 Z_vec[1]=1; out_valid exactly 5 edges after accept; in_ready=0 throughout.
- out_ready held 0 for 3 cycles in HOLD while in_valid=1 with new operands -> outputs stable, no accept. Raise out_ready -> retire; the new op is accepted the next cycle.
- Opcode 5'b11000 -> illegal_op=1, out_scalar=0, Z=1. Next, rst_n=0 during a vector op's third cycle -> out_valid never asserts; all outputs 0, in_ready=1 after the edge.

Source files
------------

// File: rtl/exec_unit_seq.sv
// Sequenced integer / fixed-point / vector ADD-SUB-MUL unit with valid/ready on both sides.
// Optional macro EXEC_SATURATE_EN clamps overflowed results to the signed max/min.
module exec_unit_seq #(
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned LANES           = 16,
   parameter int unsigned LANES_PER_CYCLE = 4,
   parameter int unsigned FRAC_BITS       = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [4:0]                    opcode,
   input  logic                          s_mux_A,
   input  logic                          s_mux_B,
   input  logic [DATA_WIDTH-1:0]         A_deco,
   input  logic [DATA_WIDTH-1:0]         B_deco,
   input  logic [DATA_WIDTH-1:0]         A_ua,
   input  logic [DATA_WIDTH-1:0]         B_ua,
   input  logic [LANES*DATA_WIDTH-1:0]   A_deco_vec,
   input  logic [LANES*DATA_WIDTH-1:0]   B_deco_vec,
   input  logic [LANES*DATA_WIDTH-1:0]   A_ua_vec,
   input  logic [LANES*DATA_WIDTH-1:0]   B_ua_vec,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_scalar,
   output logic [LANES*DATA_WIDTH-1:0]   out_vector,
   output logic [1:0]                    out_class,
   output logic                          N,
   output logic                          V,
   output logic                          Z,
   output logic [LANES-1:0]              N_vec,
   output logic [LANES-1:0]              V_vec,
   output logic [LANES-1:0]              Z_vec,
   output logic                          illegal_op,
   output logic                          busy
);

   localparam int unsigned CHUNKS = LANES / LANES_PER_CYCLE;
   localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int unsigned VW     = LANES * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, SCALAR, VEC, HOLD} state_t;

   typedef struct packed {
      logic                  n;
      logic                  v;
      logic                  z;
      logic [DATA_WIDTH-1:0] res;
   } alu_t;

   // The double-width "true" result decides both overflow and saturation direction.
   function automatic alu_t alu_op(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                                   input logic frac_mul, input logic [2:0] op);
      logic signed [2*DATA_WIDTH-1:0] ea, eb, full;
      alu_t r;
      ea = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
      eb = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
      unique case (op)
         3'd0:    full = ea + eb;
         3'd1:    full = ea - eb;
         3'd2:    full = frac_mul ? ((ea * eb) >>> FRAC_BITS) : (ea * eb);
         default: full = '0;
      endcase
      r.v   = (full[2*DATA_WIDTH-1:DATA_WIDTH-1] != '0) && (full[2*DATA_WIDTH-1:DATA_WIDTH-1] != '1);
      r.res = full[DATA_WIDTH-1:0];
`ifdef EXEC_SATURATE_EN
      if (r.v) r.res = full[2*DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
      r.n = r.res[DATA_WIDTH-1];
      r.z = (r.res == '0);
      return r;
   endfunction

   state_t                state_q, state_d;
   logic                  in_ready_q, in_ready_d, busy_q, busy_d, out_valid_q, out_valid_d;
   logic [1:0]            cls_q, cls_d, out_class_q, out_class_d;
   logic [2:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, out_scalar_q, out_scalar_d;
   logic [VW-1:0]         a_vec_q, a_vec_d, b_vec_q, b_vec_d, out_vector_q, out_vector_d;
   logic [CW-1:0]         chunk_q, chunk_d;
   logic                  n_q, n_d, v_q, v_d, z_q, z_d, illegal_q, illegal_d;
   logic [LANES-1:0]      n_vec_q, n_vec_d, v_vec_q, v_vec_d, z_vec_q, z_vec_d;

   always_comb begin
      alu_t        r;
      int unsigned lane;
      logic        in_legal, op_legal;
      r            = '0;
      lane         = 0;
      in_legal     = (opcode[4:3] != 2'b11) && (opcode[2:0] <= 3'd2);
      op_legal     = (cls_q != 2'b11) && (op_q <= 3'd2);
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      cls_d        = cls_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      a_vec_d      = a_vec_q;
      b_vec_d      = b_vec_q;
      chunk_d      = chunk_q;
      out_scalar_d = out_scalar_q;
      out_vector_d = out_vector_q;
      out_class_d  = out_class_q;
      n_d          = n_q;
      v_d          = v_q;
      z_d          = z_q;
      n_vec_d      = n_vec_q;
      v_vec_d      = v_vec_q;
      z_vec_d      = z_vec_q;
      illegal_d    = illegal_q;
      unique case (state_q)
         IDLE: if (in_valid) begin
            cls_d   = opcode[4:3];
            op_d    = opcode[2:0];
            a_d     = s_mux_A ? A_ua : A_deco;
            b_d     = s_mux_B ? B_ua : B_deco;
            a_vec_d = s_mux_A ? A_ua_vec : A_deco_vec;
            b_vec_d = s_mux_B ? B_ua_vec : B_deco_vec;
            chunk_d = '0;
            if (in_legal) illegal_d = 1'b0;
            state_d = (in_legal && opcode[4:3] == 2'b10) ? VEC : SCALAR;
         end
         SCALAR: begin
            out_class_d = cls_q;
            if (op_legal) begin
               r            = alu_op(a_q, b_q, cls_q == 2'b01, op_q);
               out_scalar_d = r.res;
               {n_d, v_d, z_d} = {r.n, r.v, r.z};
            end else begin
               out_scalar_d    = '0;
               {n_d, v_d, z_d} = 3'b001;
               illegal_d       = 1'b1;
            end
            state_d = HOLD;
         end
         VEC: begin
            out_class_d = 2'b10;
            for (int unsigned j = 0; j < LANES_PER_CYCLE; j++) begin
               lane = 32'(chunk_q) * LANES_PER_CYCLE + j;
               r    = alu_op(a_vec_q[lane*DATA_WIDTH +: DATA_WIDTH], b_vec_q[lane*DATA_WIDTH +: DATA_WIDTH],
                             1'b0, op_q);
               out_vector_d[lane*DATA_WIDTH +: DATA_WIDTH] = r.res;
               n_vec_d[lane] = r.n;
               v_vec_d[lane] = r.v;
               z_vec_d[lane] = r.z;
            end
            chunk_d = chunk_q + 1'b1;
            if (chunk_q == CW'(CHUNKS - 1)) state_d = HOLD;
         end
         HOLD: begin
            // out_valid rises one edge after entering HOLD, giving the documented latencies.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         cls_q        <= '0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         a_vec_q      <= '0;
         b_vec_q      <= '0;
         chunk_q      <= '0;
         out_scalar_q <= '0;
         out_vector_q <= '0;
         out_class_q  <= '0;
         n_q          <= 1'b0;
         v_q          <= 1'b0;
         z_q          <= 1'b0;
         n_vec_q      <= '0;
         v_vec_q      <= '0;
         z_vec_q      <= '0;
         illegal_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
         out_valid_q  <= out_valid_d;
         cls_q        <= cls_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         a_vec_q      <= a_vec_d;
         b_vec_q      <= b_vec_d;
         chunk_q      <= chunk_d;
         out_scalar_q <= out_scalar_d;
         out_vector_q <= out_vector_d;
         out_class_q  <= out_class_d;
         n_q          <= n_d;
         v_q          <= v_d;
         z_q          <= z_d;
         n_vec_q      <= n_vec_d;
         v_vec_q      <= v_vec_d;
         z_vec_q      <= z_vec_d;
         illegal_q    <= illegal_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign busy       = busy_q;
   assign out_valid  = out_valid_q;
   assign out_scalar = out_scalar_q;
   assign out_vector = out_vector_q;
   assign out_class  = out_class_q;
   assign N          = n_q;
   assign V          = v_q;
   assign Z          = z_q;
   assign N_vec      = n_vec_q;
   assign V_vec      = v_vec_q;
   assign Z_vec      = z_vec_q;
   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_exec_unit_seq.sv
// Directed bench for exec_unit_seq: arithmetic model computed at accept, checked every out_valid cycle.
module tb_exec_unit_seq;
   localparam int DW = 16, LN = 16, LPC = 4, FB = 8, VW = LN * DW;

   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, s_mux_A = 1'b0, s_mux_B = 1'b0;
   logic [4:0]    opcode = '0;
   logic [DW-1:0] A_deco = '0, B_deco = '0, A_ua = '0, B_ua = '0;
   logic [VW-1:0] A_deco_vec = '0, B_deco_vec = '0, A_ua_vec = '0, B_ua_vec = '0;
   logic          in_ready, out_valid, N, V, Z, illegal_op, busy;
   logic [DW-1:0] out_scalar;
   logic [VW-1:0] out_vector;
   logic [1:0]    out_class;
   logic [LN-1:0] N_vec, V_vec, Z_vec;

   int n_checks = 0, n_fail = 0;

   logic [DW-1:0] exp_scalar;
   logic [2:0]    exp_nvz;
   logic [VW-1:0] exp_vec;
   logic [LN-1:0] exp_nv, exp_vv, exp_zv;
   logic [1:0]    exp_class;
   logic          exp_ill;
   int            exp_lat;

   exec_unit_seq #(.DATA_WIDTH(DW), .LANES(LN), .LANES_PER_CYCLE(LPC), .FRAC_BITS(FB)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .s_mux_A(s_mux_A), .s_mux_B(s_mux_B), .A_deco(A_deco), .B_deco(B_deco), .A_ua(A_ua), .B_ua(B_ua),
      .A_deco_vec(A_deco_vec), .B_deco_vec(B_deco_vec), .A_ua_vec(A_ua_vec), .B_ua_vec(B_ua_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_scalar(out_scalar), .out_vector(out_vector),
      .out_class(out_class), .N(N), .V(V), .Z(Z), .N_vec(N_vec), .V_vec(V_vec), .Z_vec(Z_vec),
      .illegal_op(illegal_op), .busy(busy));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Plain signed arithmetic on the mathematical value, then wrap or clamp.
   function automatic void model_elem(input logic [DW-1:0] a, input logic [DW-1:0] b, input int op,
                                      input bit fixed, output logic [DW-1:0] r, output logic [2:0] nvz);
      longint sa, sb, t, scale, maxv, minv;
      logic   v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      scale = longint'(1) << FB;
      maxv = (longint'(1) << (DW - 1)) - 1;
      minv = -(longint'(1) << (DW - 1));
      if (op == 0) t = sa + sb;
      else if (op == 1) t = sa - sb;
      else t = sa * sb;
      if (fixed && op == 2) t = (t >= 0) ? t / scale : -((-t + scale - 1) / scale);
      v = (t > maxv) || (t < minv);
      r = t[DW-1:0];
`ifdef EXEC_SATURATE_EN
      if (v) r = (t > 0) ? maxv[DW-1:0] : minv[DW-1:0];
`endif
      nvz = {r[DW-1], v, r == '0};
   endfunction

   task automatic model_reset();
      exp_scalar = '0; exp_nvz = '0; exp_vec = '0; exp_nv = '0; exp_vv = '0; exp_zv = '0;
      exp_class = '0; exp_ill = 1'b0; exp_lat = 0;
   endtask

   task automatic model_compute();
      logic [1:0]    cls;
      int            op;
      logic [DW-1:0] a, b, r;
      logic [VW-1:0] av, bv;
      logic [2:0]    nvz;
      cls = opcode[4:3];
      op  = int'(opcode[2:0]);
      a   = s_mux_A ? A_ua : A_deco;
      b   = s_mux_B ? B_ua : B_deco;
      av  = s_mux_A ? A_ua_vec : A_deco_vec;
      bv  = s_mux_B ? B_ua_vec : B_deco_vec;
      exp_class = cls;
      if (cls == 2'b11 || op > 2) begin
         exp_scalar = '0; exp_nvz = 3'b001; exp_ill = 1'b1; exp_lat = 2;
      end else if (cls == 2'b10) begin
         exp_ill = 1'b0; exp_lat = LN / LPC + 1;
         for (int i = 0; i < LN; i++) begin
            model_elem(av[i*DW +: DW], bv[i*DW +: DW], op, 1'b0, r, nvz);
            exp_vec[i*DW +: DW] = r;
            {exp_nv[i], exp_vv[i], exp_zv[i]} = nvz;
         end
      end else begin
         exp_ill = 1'b0; exp_lat = 2;
         model_elem(a, b, op, cls == 2'b01, r, nvz);
         exp_scalar = r; exp_nvz = nvz;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         check("out_scalar", out_scalar, exp_scalar);
         check("scalar_flags", {N, V, Z}, exp_nvz);
         check("out_vector", out_vector, exp_vec);
         check("vec_flags", {N_vec, V_vec, Z_vec}, {exp_nv, exp_vv, exp_zv});
         check("out_class", out_class, exp_class);
         check("illegal_op", illegal_op, exp_ill);
         check("hold_ready_busy", {in_ready, busy}, 2'b01);
      end
   end

   task automatic accept_op();
      @(negedge clk);
      check("ready_before_accept", {in_ready, busy}, 2'b10);
      model_compute();
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result();
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
         if (!out_valid) check("ready_busy_in_flight", {in_ready, busy}, 2'b01);
      end
      check("latency", lat, exp_lat);
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("after_retire", {out_valid, in_ready, busy}, 3'b010);
   endtask

   task automatic check_reset_outputs();
      check("reset_outputs", {out_valid, out_scalar, out_class, N, V, Z, N_vec, V_vec, Z_vec, illegal_op, busy}, '0);
      check("reset_vector", out_vector, '0);
      check("reset_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_reset_outputs();
      rst_n = 1'b1;

      // int ADD, A from decode, B from UA; operand change after accept must not matter
      opcode = 5'b00_000; s_mux_A = 1'b0; s_mux_B = 1'b1;
      A_deco = 16'h0005; B_ua = 16'h0003; A_ua = 16'h1111; B_deco = 16'h2222;
      accept_op();
      A_deco = 16'h4444; B_ua = 16'h5555;
      wait_result();
      check("add_lit", {out_scalar, N, V, Z}, {16'h0008, 3'b000});
      retire();

      // int ADD signed overflow
      s_mux_A = 1'b0; s_mux_B = 1'b0; A_deco = 16'h7FFF; B_deco = 16'h0001;
      accept_op(); wait_result();
`ifdef EXEC_SATURATE_EN
      check("ovf_lit", {out_scalar, N, V, Z}, {16'h7FFF, 3'b010});
`else
      check("ovf_lit", {out_scalar, N, V, Z}, {16'h8000, 3'b110});
`endif
      retire();

      // fixed MUL 1.5 * 2.0, fixed SUB to zero, negative fixed MUL rounding toward -inf
      opcode = 5'b01_010; A_deco = 16'h0180; B_deco = 16'h0200;
      accept_op(); wait_result();
      check("fmul_lit", {out_scalar, N, V, Z}, {16'h0300, 3'b000});
      retire();
      opcode = 5'b01_001; A_deco = 16'h0100; B_deco = 16'h0100;
      accept_op(); wait_result();
      check("fsub_lit", {out_scalar, N, V, Z}, {16'h0000, 3'b001});
      retire();
      opcode = 5'b01_010; A_deco = 16'hFFFF; B_deco = 16'h0080;
      accept_op(); wait_result();
      check("fmul_floor_lit", out_scalar, 16'hFFFF);
      retire();
      opcode = 5'b00_010; A_deco = 16'h0100; B_deco = 16'h0100;
      accept_op(); wait_result(); retire();

      // vector SUB lane i: i - 1
      for (int i = 0; i < LN; i++) begin
         A_deco_vec[i*DW +: DW] = DW'(i);
         B_ua_vec[i*DW +: DW]   = 16'h0001;
         A_ua_vec[i*DW +: DW]   = 16'hAAAA;
         B_deco_vec[i*DW +: DW] = 16'h5555;
      end
      opcode = 5'b10_001; s_mux_A = 1'b0; s_mux_B = 1'b1;
      accept_op(); wait_result();
      check("vsub_lane0", out_vector[15:0], 16'hFFFF);
      check("vsub_flags_lit", {N_vec, V_vec, Z_vec}, {16'h0001, 16'h0000, 16'h0002});
      retire();

      // vector ADD crossing the positive limit from lane 4 upward
      for (int i = 0; i < LN; i++) begin
         A_ua_vec[i*DW +: DW]   = 16'h7FF0 + DW'(i);
         B_deco_vec[i*DW +: DW] = 16'h000C;
      end
      opcode = 5'b10_000; s_mux_A = 1'b1; s_mux_B = 1'b0;
      accept_op(); wait_result();
      check("vadd_v_lit", V_vec, 16'hFFF0);
      retire();

      // stalled HOLD with a competing request, then retire and accept on the next cycle
      opcode = 5'b00_001; s_mux_A = 1'b0; s_mux_B = 1'b0; A_deco = 16'h0003; B_deco = 16'h0005;
      accept_op(); wait_result();
      opcode = 5'b00_010; A_deco = 16'h0003; B_deco = 16'h0004; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1 check("stall_hold", {out_valid, in_ready, out_scalar}, {2'b10, 16'hFFFE});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("retire_no_accept", {out_valid, in_ready, busy}, 3'b010);
      accept_op(); wait_result();
      check("mul_lit", out_scalar, 16'h000C);
      retire();

      // illegal opcode, then a legal op clears illegal_op
      opcode = 5'b11_000;
      accept_op(); wait_result();
      check("illegal_lit", {illegal_op, out_scalar, N, V, Z}, {1'b1, 16'h0000, 3'b001});
      retire();
      opcode = 5'b00_000; A_deco = 16'h0001; B_deco = 16'h0001;
      accept_op(); wait_result();
      check("illegal_cleared", {illegal_op, out_scalar}, {1'b0, 16'h0002});
      retire();

      // reset during the third vector cycle abandons the operation
      opcode = 5'b10_010;
      accept_op();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      check_reset_outputs();
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1 check("no_valid_after_reset", {out_valid, busy}, 2'b00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
